// File: rtl/gbe_tx_packetizer.sv
// gbe_tx_packetizer: frames a continuous 64-bit sample stream into fixed-length UDP payloads
// for the ten_gb_eth user TX port. Each packet is one header word {seq[47:0], length[15:0]}
// followed by PAYLOAD_WORDS buffered sample words, paced by the core's tx_afull.
// Build option: define GBE_PKT_TRAILER_EN to append one trailer word holding the XOR of the
// packet's payload words; tx_end_of_frame then moves to the trailer.
module gbe_tx_packetizer #(
    parameter int unsigned PAYLOAD_WORDS = 128,
    parameter int unsigned FIFO_AW       = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din_valid,
    input  logic [63:0] din_data,
    input  logic        din_sync,
    input  logic        cfg_en,
    input  logic [31:0] cfg_dest_ip,
    input  logic [15:0] cfg_dest_port,
    input  logic        tx_afull,
    input  logic        tx_overflow,
    output logic        tx_valid,
    output logic [63:0] tx_data,
    output logic        tx_end_of_frame,
    output logic [31:0] tx_dest_ip,
    output logic [15:0] tx_dest_port,
    output logic [31:0] pkt_count,
    output logic [31:0] drop_count,
    output logic        ovf_err
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CW    = $clog2(PAYLOAD_WORDS);

    localparam logic [CW-1:0]    LAST_IDX   = CW'(PAYLOAD_WORDS - 1);
    localparam logic [FIFO_AW:0] PKT_LEVEL  = (FIFO_AW + 1)'(PAYLOAD_WORDS);
    localparam logic [FIFO_AW:0] FULL_LEVEL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0] CNT_ONE    = (FIFO_AW + 1)'(1);
    localparam logic [15:0]      LEN_FIELD  = 16'(PAYLOAD_WORDS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_PAY  = 2'd2;
`ifdef GBE_PKT_TRAILER_EN
    localparam logic [1:0] ST_TRL  = 2'd3;
`endif

    logic [63:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q, count_d;
    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      pay_cnt_q;
    logic [47:0]        seq_q;
    logic               sync_pend_q;

    logic               tx_valid_q, tx_eof_q, ovf_err_q;
    logic [63:0]        tx_data_q;
    logic [31:0]        tx_dest_ip_q, pkt_count_q, drop_count_q;
    logic [15:0]        tx_dest_port_q;

    logic               wr_req, full, sync_now, start, pop, wr_ok, last_pay;
    logic               eof_issue, word_issue;
    logic [63:0]        rd_data;

    assign wr_req   = din_valid & cfg_en;
    assign full     = (count_q == FULL_LEVEL);
    // A sync only takes effect between packets; the in-flight packet is never cut short.
    assign sync_now = (state_q == ST_IDLE) & (din_sync | sync_pend_q);
    // The eof cycle is already IDLE; skipping it guarantees one idle cycle between packets.
    assign start    = (state_q == ST_IDLE) & ~sync_now & ~tx_eof_q &
                      (count_q >= PKT_LEVEL) & ~tx_afull;
    assign pop      = ((state_q == ST_HDR) | (state_q == ST_PAY)) & ~tx_afull;
    // A pop or a flush in the same cycle frees room for the incoming word.
    assign wr_ok    = wr_req & (~full | pop | sync_now);
    assign last_pay = pop & (pay_cnt_q == LAST_IDX);
    assign rd_data  = mem[rd_ptr_q];

`ifdef GBE_PKT_TRAILER_EN
    logic [63:0] xor_q;
    assign eof_issue  = (state_q == ST_TRL) & ~tx_afull;
    assign word_issue = start | pop | eof_issue;

    // Running XOR of the payload words popped for the current packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xor_q <= '0;
        end else if (start) begin
            xor_q <= '0;
        end else if (pop) begin
            xor_q <= xor_q ^ rd_data;
        end
    end
`else
    assign eof_issue  = last_pay;
    assign word_issue = start | pop;
`endif

    // Buffer storage; the data array itself needs no reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= din_data;
        end
    end

    // Occupancy: a flush empties the buffer, a same-cycle write then lands as the first word.
    always_comb begin
        count_d = count_q;
        if (sync_now) begin
            count_d = '0;
        end else if (pop) begin
            count_d = count_q - CNT_ONE;
        end
        if (wr_ok) begin
            count_d = count_d + CNT_ONE;
        end
    end

    // Buffer pointers, occupancy and input drop accounting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            drop_count_q <= '0;
        end else begin
            count_q <= count_d;
            if (wr_ok) begin
                wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            end
            if (sync_now) begin
                rd_ptr_q <= wr_ptr_q;
            end else if (pop) begin
                rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            end
            if (wr_req && !wr_ok && drop_count_q != 32'hFFFF_FFFF) begin
                drop_count_q <= drop_count_q + 32'd1;
            end
        end
    end

    // Packet sequencing: IDLE -> HDR -> PAY (-> TRL) -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)    state_d = ST_HDR;
            ST_HDR:  if (pop)      state_d = ST_PAY;
`ifdef GBE_PKT_TRAILER_EN
            ST_PAY:  if (last_pay) state_d = ST_TRL;
            ST_TRL:  if (!tx_afull) state_d = ST_IDLE;
`else
            ST_PAY:  if (last_pay) state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state, payload index, sequence number, pending sync and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pay_cnt_q   <= '0;
            seq_q       <= '0;
            sync_pend_q <= 1'b0;
            ovf_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) begin
                pay_cnt_q <= '0;
            end else if (pop) begin
                pay_cnt_q <= pay_cnt_q + CW'(1);
            end
            if (sync_now) begin
                seq_q <= '0;
            end else if (eof_issue) begin
                seq_q <= seq_q + 48'd1;
            end
            if (sync_now) begin
                sync_pend_q <= 1'b0;
            end else if (din_sync) begin
                sync_pend_q <= 1'b1;
            end
            if (tx_overflow) begin
                ovf_err_q <= 1'b1;
            end else if (sync_now) begin
                ovf_err_q <= 1'b0;
            end
        end
    end

    // Registered TX interface; destination is captured once per packet at the start decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_valid_q     <= 1'b0;
            tx_eof_q       <= 1'b0;
            tx_data_q      <= '0;
            tx_dest_ip_q   <= '0;
            tx_dest_port_q <= '0;
            pkt_count_q    <= '0;
        end else begin
            tx_valid_q <= word_issue;
            tx_eof_q   <= eof_issue;
            if (start) begin
                tx_data_q      <= {seq_q, LEN_FIELD};
                tx_dest_ip_q   <= cfg_dest_ip;
                tx_dest_port_q <= cfg_dest_port;
            end else if (pop) begin
                tx_data_q <= rd_data;
            end
`ifdef GBE_PKT_TRAILER_EN
            else if (eof_issue) begin
                tx_data_q <= xor_q;
            end
`endif
            if (eof_issue) begin
                pkt_count_q <= pkt_count_q + 32'd1;
            end
        end
    end

    assign tx_valid        = tx_valid_q;
    assign tx_data         = tx_data_q;
    assign tx_end_of_frame = tx_eof_q;
    assign tx_dest_ip      = tx_dest_ip_q;
    assign tx_dest_port    = tx_dest_port_q;
    assign pkt_count       = pkt_count_q;
    assign drop_count      = drop_count_q;
    assign ovf_err         = ovf_err_q;

endmodule
